// File: rtl/spectrum_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spectrum_pkg
// Description : Shared definitions for the 512-point spectrum analyzer.
//               Provides the frame geometry, the sequencer state encoding,
//               the default butterfly drain depth and the 9-bit bit-reversal
//               helper used to map capture and readout addresses.
// Revision    : 1.0 - initial release
// ============================================================================
package spectrum_pkg;

  localparam int N_LOG2             = 9;
  localparam int N_POINTS           = 512;
  // Butterfly pipeline depth: drain cycles inserted after every stage.
  localparam int BF_LATENCY_DEFAULT = 3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CAPTURE = 3'd1,
    ST_COMPUTE = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_READOUT = 3'd4,
    ST_DONE    = 3'd5
  } seq_state_e;

  // Mirror the 9 address bits: bit i moves to bit 8-i.
  function automatic logic [8:0] bitrev9(input logic [8:0] v);
    logic [8:0] r;
    r = '0;
    for (int i = 0; i < 9; i++) begin
      r[i] = v[8-i];
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fft_frame_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : fft_frame_sequencer_if
// Description : Handshake and address bus between the frame sequencer and
//               the capture RAM, butterfly, twiddle ROM and display path.
//   start, sample_valid, rd_ready   : requests into the sequencer
//   cap_we, cap_addr                : frame RAM capture write port
//   bf_en, bf_stage, bf_idx         : butterfly issue controls
//   twiddle_addr                    : twiddle ROM address
//   rd_valid, rd_addr               : bin readout to the display path
//   busy, frame_done                : frame status
//   modport master : the sequencer; modport slave : its environment
// Revision    : 1.0 - initial release
// ============================================================================
interface fft_frame_sequencer_if;
  import spectrum_pkg::*;

  logic                start;
  logic                sample_valid;
  logic                cap_we;
  logic [N_LOG2-1:0]   cap_addr;
  logic                bf_en;
  logic [3:0]          bf_stage;
  logic [N_LOG2-2:0]   bf_idx;
  logic [N_LOG2-2:0]   twiddle_addr;
  logic                rd_valid;
  logic [N_LOG2-1:0]   rd_addr;
  logic                rd_ready;
  logic                busy;
  logic                frame_done;

  modport master (
    input  start, sample_valid, rd_ready,
    output cap_we, cap_addr, bf_en, bf_stage, bf_idx, twiddle_addr,
           rd_valid, rd_addr, busy, frame_done
  );

  modport slave (
    output start, sample_valid, rd_ready,
    input  cap_we, cap_addr, bf_en, bf_stage, bf_idx, twiddle_addr,
           rd_valid, rd_addr, busy, frame_done
  );

endinterface
`default_nettype wire

// File: rtl/fft_twiddle_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : fft_twiddle_addr_gen
// Description : Combinational twiddle ROM address for butterfly j of stage s:
//               (j mod 2^s) * 2^(8-s), formed as j << (8-s) truncated to
//               8 bits. Shared with the butterfly ROM checker.
//   idx_i          : butterfly index within the stage
//   stage_i        : stage number 0..8
//   twiddle_addr_o : twiddle ROM address
// Revision    : 1.0 - initial release
// ============================================================================
module fft_twiddle_addr_gen
  import spectrum_pkg::*;
(
  input  logic [N_LOG2-2:0] idx_i,
  input  logic [3:0]        stage_i,
  output logic [N_LOG2-2:0] twiddle_addr_o
);

  // The left shift discards the upper index bits, which is exactly the
  // "mod 2^s" term; stage 0 shifts everything out and yields address 0.
  always_comb begin
    twiddle_addr_o = idx_i << (4'(N_LOG2 - 1) - stage_i);
  end

endmodule
`default_nettype wire

// File: rtl/fft_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fft_frame_sequencer
// Description : Frame controller for the 512-point spectrum analyzer.
//               Sequences capture -> 9 butterfly stages (each followed by a
//               BF_LATENCY-cycle drain) -> bin readout -> done pulse, and
//               drives all RAM, butterfly and twiddle ROM addresses.
//   clk     : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : fft_frame_sequencer_if.master (handshakes and addresses)
// Build option: BIT_REVERSE_EN
//   defined   -> capture bit-reversed, readout natural order
//   undefined -> capture natural order, readout bit-reversed
// Revision    : 1.0 - initial release
// ============================================================================
module fft_frame_sequencer
  import spectrum_pkg::*;
#(
  parameter int N_LOG2     = 9,
  parameter int BF_LATENCY = BF_LATENCY_DEFAULT
) (
  input  logic                         clk,
  input  logic                         reset_n,
  fft_frame_sequencer_if.master        bus
);

  seq_state_e         state_q, state_d;
  logic [N_LOG2-1:0]  cnt_q,   cnt_d;
  logic [3:0]         stg_q,   stg_d;
  logic [N_LOG2-2:0]  twiddle_raw;

  fft_twiddle_addr_gen u_twiddle (
    .idx_i          (cnt_q[N_LOG2-2:0]),
    .stage_i        (stg_q),
    .twiddle_addr_o (twiddle_raw)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      stg_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stg_q   <= stg_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    stg_d            = stg_q;
    bus.cap_we       = 1'b0;
    bus.cap_addr     = '0;
    bus.bf_en        = 1'b0;
    bus.bf_stage     = '0;
    bus.bf_idx       = '0;
    bus.twiddle_addr = '0;
    bus.rd_valid     = 1'b0;
    bus.rd_addr      = '0;
    bus.busy         = 1'b1;
    bus.frame_done   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        bus.busy = 1'b0;
        if (bus.start) begin
          state_d = ST_CAPTURE;
          cnt_d   = '0;
        end
      end

      ST_CAPTURE: begin
        bus.cap_we = bus.sample_valid;
`ifdef BIT_REVERSE_EN
        bus.cap_addr = bitrev9(cnt_q);
`else
        bus.cap_addr = cnt_q;
`endif
        if (bus.sample_valid) begin
          if (cnt_q == '1) begin
            state_d = ST_COMPUTE;
            cnt_d   = '0;
            stg_d   = '0;
          end else begin
            cnt_d = cnt_q + N_LOG2'(1);
          end
        end
      end

      ST_COMPUTE: begin
        bus.bf_en        = 1'b1;
        bus.bf_stage     = stg_q;
        bus.bf_idx       = cnt_q[N_LOG2-2:0];
        bus.twiddle_addr = twiddle_raw;
        if (cnt_q[N_LOG2-2:0] == '1) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + N_LOG2'(1);
        end
      end

      // cnt doubles as the drain timer; it is zero on entry.
      ST_DRAIN: begin
        if (cnt_q == N_LOG2'(BF_LATENCY - 1)) begin
          cnt_d = '0;
          if (stg_q == 4'(N_LOG2 - 1)) begin
            state_d = ST_READOUT;
          end else begin
            stg_d   = stg_q + 4'd1;
            state_d = ST_COMPUTE;
          end
        end else begin
          cnt_d = cnt_q + N_LOG2'(1);
        end
      end

      // rd_addr follows cnt, which only moves on a handshake, so the
      // address is naturally held while the consumer stalls.
      ST_READOUT: begin
        bus.rd_valid = 1'b1;
`ifdef BIT_REVERSE_EN
        bus.rd_addr = cnt_q;
`else
        bus.rd_addr = bitrev9(cnt_q);
`endif
        if (bus.rd_ready) begin
          if (cnt_q == '1) begin
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + N_LOG2'(1);
          end
        end
      end

      ST_DONE: begin
        bus.frame_done = 1'b1;
        state_d        = ST_IDLE;
        cnt_d          = '0;
        stg_d          = '0;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_fft_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fft_frame_sequencer
// Description : Self-checking bench for fft_frame_sequencer. A stimulus
//               process pushes expected capture addresses, butterfly
//               (stage, index, twiddle) triples, readout addresses and
//               frame completions into queues; a monitor on the falling
//               edge pops and compares whenever the DUT presents them.
//               Honours BIT_REVERSE_EN the same way as the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_frame_sequencer;
  import spectrum_pkg::*;

  localparam int LAT = 3;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   cyc     = 0;

  fft_frame_sequencer_if bus ();

  fft_frame_sequencer #(
    .N_LOG2     (9),
    .BF_LATENCY (LAT)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference bit reversal by repeated halving.
  function automatic int rev9(input int v);
    int r = 0;
    int x = v;
    for (int i = 0; i < 9; i++) begin
      r = r * 2 + (x % 2);
      x = x / 2;
    end
    return r;
  endfunction

  function automatic longint all_outputs();
    return longint'({bus.cap_we, bus.cap_addr, bus.bf_en, bus.bf_stage, bus.bf_idx,
                     bus.twiddle_addr, bus.rd_valid, bus.rd_addr, bus.busy,
                     bus.frame_done});
  endfunction

  // Scoreboard
  int cap_q[$];
  int bf_q[$];
  int rd_q[$];
  int done_exp    = 0;
  int frames_done = 0;

  // Monitor tracking
  int         cap_cnt, bf_seen, hi_run, lo_run;
  int         comp_start, last_cap_cyc, last_hs_cyc;
  bit         rd_started, prev_rd_wait, post_done;
  logic [8:0] prev_rd_addr;

  always @(negedge clk) begin
    if (!reset_n) begin
      cap_cnt = 0; bf_seen = 0; hi_run = 0; lo_run = 0;
      rd_started = 0; prev_rd_wait = 0; post_done = 0;
    end else begin
      if (post_done) begin
        check("idle_after_done", {bus.busy, bus.frame_done}, 0);
        post_done = 0;
      end

      if (bus.cap_we) begin
        check("cap_q_nonempty", int'(cap_q.size() > 0), 1);
        if (cap_q.size() > 0) check("cap_addr", bus.cap_addr, cap_q.pop_front());
        cap_cnt++;
        if (cap_cnt == N_POINTS) last_cap_cyc = cyc;
      end

      if (bus.bf_en) begin
        if (bf_seen == 0) begin
          check("cap_pulses", cap_cnt, N_POINTS);
          check("compute_entry", cyc - last_cap_cyc, 1);
          comp_start = cyc;
        end else if (lo_run > 0) begin
          check("drain_gap", lo_run, LAT);
        end
        lo_run = 0;
        hi_run++;
        check("bf_q_nonempty", int'(bf_q.size() > 0), 1);
        if (bf_q.size() > 0)
          check("bf_triple", {bus.bf_stage, bus.bf_idx, bus.twiddle_addr}, bf_q.pop_front());
        if (bus.bf_stage == 4'd1 && bus.bf_idx == 8'd3)
          check("tw_s1_i3", bus.twiddle_addr, 128);
        bf_seen++;
      end else begin
        if (hi_run > 0) begin
          check("stage_len", hi_run, 256);
          hi_run = 0;
        end
        if (bf_seen > 0) lo_run++;
        check("bf_idle_zero", {bus.bf_stage, bus.bf_idx, bus.twiddle_addr}, 0);
      end

      if (bus.rd_valid) begin
        if (!rd_started) begin
          check("compute_latency", cyc - comp_start, 9 * (256 + LAT));
          rd_started = 1;
        end else if (prev_rd_wait) begin
          check("rd_hold", bus.rd_addr, prev_rd_addr);
        end
        prev_rd_wait = !bus.rd_ready;
        prev_rd_addr = bus.rd_addr;
        if (bus.rd_ready) begin
          check("rd_q_nonempty", int'(rd_q.size() > 0), 1);
          if (rd_q.size() > 0) check("rd_addr", bus.rd_addr, rd_q.pop_front());
          last_hs_cyc = cyc;
        end
      end

      if (bus.frame_done) begin
        check("done_expected", int'(done_exp > 0), 1);
        if (done_exp > 0) done_exp--;
        check("done_timing", cyc - last_hs_cyc, 1);
        check("bf_total", bf_seen, 9 * 256);
        frames_done++;
        post_done = 1;
        cap_cnt = 0; bf_seen = 0; hi_run = 0; lo_run = 0;
        rd_started = 0; prev_rd_wait = 0;
      end
    end
  end

  // One frame. mode 0: one sample per 3 cycles and rd_ready 1,0,0,1;
  // mode 1: random sample gaps and random rd_ready. abort_at >= 0 resets
  // the DUT after that many samples and leaves reset asserted.
  task automatic run_frame(input int mode, input int abort_at);
    logic [3:0] pat = 4'b1001;
    int budget;
    int k;
    int frames_before;

    for (int a = 0; a < N_POINTS; a++) begin
`ifdef BIT_REVERSE_EN
      cap_q.push_back(rev9(a));
      rd_q.push_back(a);
`else
      cap_q.push_back(a);
      rd_q.push_back(rev9(a));
`endif
    end
    for (int s = 0; s < 9; s++)
      for (int j = 0; j < 256; j++)
        bf_q.push_back(s * 65536 + j * 256 + (j % (1 << s)) * (1 << (8 - s)));
    done_exp++;

    // Reset release and start share an edge; start is seen on the next one.
    bus.start = 1'b1;
    reset_n   = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;

    for (int n = 0; n < N_POINTS; n++) begin
      int gap = (mode == 0) ? 2 : int'($urandom_range(0, 2));
      bus.sample_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
      if (n == abort_at) begin
        #2 reset_n = 1'b0;
        #1 check("abort_outputs_zero", all_outputs(), 0);
        cap_q.delete(); bf_q.delete(); rd_q.delete();
        done_exp = 0;
        repeat (2) @(posedge clk);
        #1 check("reset_hold_zero", all_outputs(), 0);
        return;
      end
      bus.sample_valid = 1'b1;
      @(posedge clk); #1;
    end
    bus.sample_valid = 1'b0;

    budget = 0;
    while (!bus.rd_valid && budget < 3000) begin
      bus.start = bus.bf_en ? ($urandom_range(0, 7) == 0) : 1'b0;
      @(posedge clk); #1;
      budget++;
    end
    bus.start = 1'b0;
    check("readout_reached", bus.rd_valid, 1);

    frames_before = frames_done;
    k = 0;
    budget = 0;
    while (frames_done == frames_before && budget < 4000) begin
      bus.rd_ready = (mode == 0) ? pat[k % 4] : 1'($urandom_range(0, 1));
      bus.start    = bus.rd_valid ? ($urandom_range(0, 3) == 0) : 1'b0;
      k++;
      @(posedge clk); #1;
      budget++;
    end
    bus.rd_ready = 1'b0;
    bus.start    = 1'b0;
    check("frame_done_count", frames_done, frames_before + 1);
    repeat (3) @(posedge clk);
    #1 check("idle_busy", bus.busy, 0);
  endtask

  initial begin
    bus.start        = 1'b0;
    bus.sample_valid = 1'b0;
    bus.rd_ready     = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("reset_outputs_zero", all_outputs(), 0);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 check("idle_outputs_zero", all_outputs(), 0);

    run_frame(0, 100);   // aborted mid-capture, reset left asserted
    run_frame(0, -1);    // released together with start
    run_frame(1, -1);

    check("cap_q_left", cap_q.size(), 0);
    check("bf_q_left", bf_q.size(), 0);
    check("rd_q_left", rd_q.size(), 0);
    check("done_left", done_exp, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
